// File: rtl/lpf_mem_port_pkg.sv
// Shared widths, default geometry and FSM states for the LPF memory port.
package lpf_mem_port_pkg;

    localparam int unsigned DEF_IMAGE_WIDTH  = 640;
    localparam int unsigned DEF_IMAGE_HEIGHT = 480;
    localparam int unsigned LOG_WIDTH        = 10;
    localparam int unsigned LOG_HEIGHT       = 9;
    localparam int unsigned LOG_MEM          = 36;
    localparam int unsigned LOG_TRUNC        = 18;
    localparam int unsigned LOG_ADDR         = 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_DONE
    } state_t;

    // y*320 as two shifts; the result fits the 18-bit product width.
    function automatic logic [LOG_TRUNC-1:0] row_offset(input logic [LOG_HEIGHT-1:0] y);
        logic [LOG_TRUNC-1:0] yw;
        yw = LOG_TRUNC'(y);
        return (yw << 8) + (yw << 6);
    endfunction

endpackage

// File: rtl/lpf_addr_gen.sv
// Registered (x, y, buf_sel) -> word address and out-of-range flag; loads only on accept.
module lpf_addr_gen
    import lpf_mem_port_pkg::*;
#(
    parameter int unsigned          IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned          IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter logic [LOG_ADDR-1:0]  BASE_A       = 19'd0,
    parameter logic [LOG_ADDR-1:0]  BASE_B       = 19'd153600
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LOG_WIDTH-1:0]  x,
    input  logic [LOG_HEIGHT-1:0] y,
    input  logic                  buf_sel,
    output logic [LOG_ADDR-1:0]   addr,
    output logic                  oob
);

    logic [LOG_ADDR-1:0]  base;
    logic [LOG_TRUNC-1:0] prod;
    logic [LOG_ADDR-1:0]  addr_next;
    logic                 oob_next;

    always_comb begin
        base      = buf_sel ? BASE_B : BASE_A;
        prod      = row_offset(y);
        addr_next = base + LOG_ADDR'(prod) + LOG_ADDR'(x[LOG_WIDTH-1:1]);
        oob_next  = (32'(x) >= IMAGE_WIDTH) || (32'(y) >= IMAGE_HEIGHT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            oob  <= 1'b0;
        end else if (load) begin
            addr <= addr_next;
            oob  <= oob_next;
        end
    end

endmodule

// File: rtl/lpf_mem_port.sv
// Responder for LPF pixel-pair requests: one 2-cycle-latency ZBT access per request,
// done_lpf four cycles after accept, at most one accept every five cycles.
module lpf_mem_port
    import lpf_mem_port_pkg::*;
#(
    parameter int unsigned  IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned  IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter logic [18:0]  BASE_A       = 19'd0,
    parameter logic [18:0]  BASE_B       = 19'd153600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_flag,
    input  logic        lpf_flag,
    input  logic        lpf_wr,
    input  logic [9:0]  lpf_x,
    input  logic [8:0]  lpf_y,
    input  logic [35:0] lpf_pixel_write,
    output logic [35:0] lpf_pixel_read,
    output logic        done_lpf,
    input  logic        ram_grant,
    output logic        ram_req,
    output logic [18:0] ram_addr,
    output logic        ram_we_b,
    output logic [35:0] ram_data_out,
    output logic        ram_drive,
    input  logic [35:0] ram_data_in,
    output logic        buf_sel,
    output logic        lpf_oob
);

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                wr_q;
    logic [LOG_MEM-1:0]  wdata_q;
    logic                addr_oob;

    assign accept = (state == S_IDLE) && lpf_flag && ram_grant;

    lpf_addr_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .BASE_A       (BASE_A),
        .BASE_B       (BASE_B)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .x       (lpf_x),
        .y       (lpf_y),
        .buf_sel (buf_sel),
        .addr    (ram_addr),
        .oob     (addr_oob)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // DONE always returns to IDLE, so the still-high flag of the finished request is never accepted.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept) state_next = S_ADDR;
            S_ADDR:  state_next = S_WAIT;
            S_WAIT:  state_next = S_DATA;
            S_DATA:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_req      = 1'b0;
        ram_we_b     = 1'b1;
        ram_drive    = 1'b0;
        ram_data_out = '0;
        done_lpf     = 1'b0;
        unique case (state)
            S_IDLE: ram_req = lpf_flag;
            S_ADDR: begin
                ram_req  = 1'b1;
                ram_we_b = ~(wr_q & ~addr_oob);
            end
            S_WAIT: ram_req = 1'b1;
            S_DATA: begin
                ram_req = 1'b1;
                if (wr_q && !addr_oob) begin
                    ram_drive    = 1'b1;
                    ram_data_out = wdata_q;
                end
            end
            S_DONE:  done_lpf = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q           <= 1'b0;
            wdata_q        <= '0;
            lpf_pixel_read <= '0;
            lpf_oob        <= 1'b0;
            buf_sel        <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= lpf_wr;
                wdata_q <= lpf_pixel_write;
            end
            if (state == S_DATA && !wr_q)
                lpf_pixel_read <= addr_oob ? '0 : ram_data_in;
            if (state == S_ADDR && addr_oob)
                lpf_oob <= 1'b1;
            // The accept above samples buf_sel before this toggle lands.
            if (frame_flag)
                buf_sel <= ~buf_sel;
        end
    end

endmodule

// File: tb/tb_lpf_mem_port.sv
// Randomized and directed checks of lpf_mem_port against a behavioural request model.
module tb_lpf_mem_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_flag;
    logic        lpf_flag;
    logic        lpf_wr;
    logic [9:0]  lpf_x;
    logic [8:0]  lpf_y;
    logic [35:0] lpf_pixel_write;
    logic [35:0] lpf_pixel_read;
    logic        done_lpf;
    logic        ram_grant;
    logic        ram_req;
    logic [18:0] ram_addr;
    logic        ram_we_b;
    logic [35:0] ram_data_out;
    logic        ram_drive;
    logic [35:0] ram_data_in;
    logic        buf_sel;
    logic        lpf_oob;

    lpf_mem_port dut (
        .clock           (clock),
        .reset           (reset),
        .frame_flag      (frame_flag),
        .lpf_flag        (lpf_flag),
        .lpf_wr          (lpf_wr),
        .lpf_x           (lpf_x),
        .lpf_y           (lpf_y),
        .lpf_pixel_write (lpf_pixel_write),
        .lpf_pixel_read  (lpf_pixel_read),
        .done_lpf        (done_lpf),
        .ram_grant       (ram_grant),
        .ram_req         (ram_req),
        .ram_addr        (ram_addr),
        .ram_we_b        (ram_we_b),
        .ram_data_out    (ram_data_out),
        .ram_drive       (ram_drive),
        .ram_data_in     (ram_data_in),
        .buf_sel         (buf_sel),
        .lpf_oob         (lpf_oob)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference state: current frame buffer, sticky out-of-range, RAM contents.
    logic        buf_m = 1'b0;
    logic        oob_m = 1'b0;
    logic [35:0] mem [int];

    // Observations from one transaction.
    logic [18:0] o_addr;
    int          o_we_cnt, o_we_cyc, o_drv_cnt, o_drv_cyc, o_done_cnt, o_done_cyc, o_done_abs, o_wait_bad;
    logic [35:0] o_drv_data, o_rval;
    logic [4:0]  o_req;

    function automatic int exp_addr(input logic b, input int x, input int y);
        return (b ? 153600 : 0) + y * 320 + x / 2;
    endfunction

    function automatic logic [35:0] rand36();
        logic [35:0] v;
        v = {4'($urandom), 32'($urandom)};
        return v;
    endfunction

    // Drives one request (waiting gdelay cycles without grant) and records what the port did.
    task automatic run_txn(input logic wr, input logic [9:0] x, input logic [8:0] y,
                           input logic [35:0] wd, input logic [35:0] rd,
                           input int gdelay, input logic ff, input logic keep);
        lpf_flag = 1'b1; lpf_wr = wr; lpf_x = x; lpf_y = y; lpf_pixel_write = wd;
        ram_grant = 1'b0; frame_flag = 1'b0;
        o_wait_bad = 0; o_we_cnt = 0; o_we_cyc = -1; o_drv_cnt = 0; o_drv_cyc = -1;
        o_done_cnt = 0; o_done_cyc = -1; o_done_abs = -1; o_drv_data = '0; o_rval = '0;
        o_addr = '0; o_req = '0;
        for (int i = 0; i < gdelay; i++) begin
            ram_data_in = rand36();
            @(negedge clock);
            if (ram_req !== 1'b1 || ram_we_b !== 1'b1 || ram_drive !== 1'b0 || done_lpf !== 1'b0)
                o_wait_bad++;
            @(posedge clock); #1;
        end
        ram_grant = 1'b1; frame_flag = ff;
        for (int c = 0; c < 5; c++) begin
            ram_data_in = (c == 3) ? rd : rand36();
            @(negedge clock);
            o_req[c] = ram_req;
            if (c == 1) o_addr = ram_addr;
            if (ram_we_b === 1'b0) begin o_we_cnt++; o_we_cyc = c; end
            if (ram_drive === 1'b1) begin o_drv_cnt++; o_drv_cyc = c; o_drv_data = ram_data_out; end
            if (done_lpf === 1'b1) begin
                o_done_cnt++; o_done_cyc = c; o_done_abs = cyc; o_rval = lpf_pixel_read;
            end
            @(posedge clock); #1;
            if (c == 0) frame_flag = 1'b0;
        end
        if (!keep) begin lpf_flag = 1'b0; ram_grant = 1'b0; end
    endtask

    task automatic test_reset();
        total++; if (ram_we_b !== 1'b1) begin bad++; $display("FAIL reset_we_b got %0b want 1", ram_we_b); end
        total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL reset_req got %0b want 0", ram_req); end
        total++; if (done_lpf !== 1'b0) begin bad++; $display("FAIL reset_done got %0b want 0", done_lpf); end
        total++; if (ram_drive !== 1'b0) begin bad++; $display("FAIL reset_drive got %0b want 0", ram_drive); end
        total++; if (ram_addr !== 19'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
        total++; if (ram_data_out !== 36'd0) begin bad++; $display("FAIL reset_dout got %h want 0", ram_data_out); end
        total++; if (lpf_pixel_read !== 36'd0) begin bad++; $display("FAIL reset_read got %h want 0", lpf_pixel_read); end
        total++; if (buf_sel !== 1'b0) begin bad++; $display("FAIL reset_buf got %0b want 0", buf_sel); end
        total++; if (lpf_oob !== 1'b0) begin bad++; $display("FAIL reset_oob got %0b want 0", lpf_oob); end
    endtask

    task automatic test_read();
        run_txn(1'b0, 10'd5, 9'd2, 36'h0, 36'hABCDE1234, 0, 1'b0, 1'b0);
        total++; if (o_addr !== 19'(exp_addr(1'b0, 5, 2))) begin bad++; $display("FAIL read_addr got %0d want %0d", o_addr, exp_addr(1'b0, 5, 2)); end
        total++; if (o_done_cyc !== 4 || o_done_cnt !== 1) begin bad++; $display("FAIL read_done got cyc %0d cnt %0d want 4/1", o_done_cyc, o_done_cnt); end
        total++; if (o_rval !== 36'hABCDE1234) begin bad++; $display("FAIL read_data got %h want ABCDE1234", o_rval); end
        total++; if (o_we_cnt !== 0 || o_drv_cnt !== 0) begin bad++; $display("FAIL read_no_write got we %0d drv %0d want 0/0", o_we_cnt, o_drv_cnt); end
        total++; if (o_req !== 5'b01111) begin bad++; $display("FAIL read_req got %b want 01111", o_req); end
        total++; if (lpf_pixel_read !== 36'hABCDE1234) begin bad++; $display("FAIL read_hold got %h want ABCDE1234", lpf_pixel_read); end
        mem[exp_addr(1'b0, 5, 2)] = 36'hABCDE1234;
    endtask

    task automatic test_write();
        frame_flag = 1'b1; @(posedge clock); #1; frame_flag = 1'b0; buf_m = ~buf_m;
        total++; if (buf_sel !== buf_m) begin bad++; $display("FAIL frame_toggle got %0b want %0b", buf_sel, buf_m); end
        run_txn(1'b1, 10'd638, 9'd479, 36'h123456789, rand36(), 0, 1'b0, 1'b0);
        total++; if (o_addr !== 19'd307199) begin bad++; $display("FAIL write_addr got %0d want 307199", o_addr); end
        total++; if (o_we_cnt !== 1 || o_we_cyc !== 1) begin bad++; $display("FAIL write_we got cnt %0d cyc %0d want 1/1", o_we_cnt, o_we_cyc); end
        total++; if (o_drv_cnt !== 1 || o_drv_cyc !== 3) begin bad++; $display("FAIL write_drive got cnt %0d cyc %0d want 1/3", o_drv_cnt, o_drv_cyc); end
        total++; if (o_drv_data !== 36'h123456789) begin bad++; $display("FAIL write_data got %h want 123456789", o_drv_data); end
        total++; if (o_done_cyc !== 4 || o_done_cnt !== 1) begin bad++; $display("FAIL write_done got cyc %0d cnt %0d want 4/1", o_done_cyc, o_done_cnt); end
        mem[307199] = 36'h123456789;
    endtask

    task automatic test_back_to_back();
        int first_abs;
        logic [35:0] wd;
        wd = rand36();
        run_txn(1'b1, 10'd100, 9'd10, wd, rand36(), 0, 1'b0, 1'b1);
        first_abs = o_done_abs;
        total++; if (o_done_cnt !== 1 || o_we_cnt !== 1) begin bad++; $display("FAIL b2b_first got done %0d we %0d want 1/1", o_done_cnt, o_we_cnt); end
        mem[exp_addr(buf_m, 100, 10)] = wd;
        run_txn(1'b0, 10'd100, 9'd10, 36'h0, wd, 0, 1'b0, 1'b1);
        total++; if (o_done_abs - first_abs !== 5) begin bad++; $display("FAIL b2b_spacing got %0d want 5", o_done_abs - first_abs); end
        total++; if (o_rval !== wd || o_done_cyc !== 4) begin bad++; $display("FAIL b2b_second got %h cyc %0d want %h/4", o_rval, o_done_cyc, wd); end
        lpf_flag = 1'b0; ram_grant = 1'b0;
        o_done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done_lpf === 1'b1 || ram_we_b === 1'b0) o_done_cnt++;
            @(posedge clock); #1;
        end
        total++; if (o_done_cnt !== 0) begin bad++; $display("FAIL b2b_extra got %0d want 0", o_done_cnt); end
    endtask

    task automatic test_grant_wait();
        logic [35:0] wd;
        wd = rand36();
        run_txn(1'b1, 10'd33, 9'd77, wd, rand36(), 7, 1'b0, 1'b0);
        total++; if (o_wait_bad !== 0) begin bad++; $display("FAIL grant_wait got %0d bad cycles want 0", o_wait_bad); end
        total++; if (o_done_cyc !== 4) begin bad++; $display("FAIL grant_done got %0d want 4", o_done_cyc); end
        total++; if (o_addr !== 19'(exp_addr(buf_m, 33, 77))) begin bad++; $display("FAIL grant_addr got %0d want %0d", o_addr, exp_addr(buf_m, 33, 77)); end
        total++; if (o_drv_data !== wd) begin bad++; $display("FAIL grant_data got %h want %h", o_drv_data, wd); end
        mem[exp_addr(buf_m, 33, 77)] = wd;
    endtask

    task automatic test_oob();
        run_txn(1'b0, 10'd20, 9'd480, 36'h0, rand36(), 0, 1'b0, 1'b0);
        oob_m = 1'b1;
        total++; if (o_we_cnt !== 0 || o_drv_cnt !== 0) begin bad++; $display("FAIL oob_ram got we %0d drv %0d want 0/0", o_we_cnt, o_drv_cnt); end
        total++; if (o_done_cyc !== 4) begin bad++; $display("FAIL oob_done got %0d want 4", o_done_cyc); end
        total++; if (o_rval !== 36'd0) begin bad++; $display("FAIL oob_read got %h want 0", o_rval); end
        total++; if (lpf_oob !== 1'b1) begin bad++; $display("FAIL oob_flag got %0b want 1", lpf_oob); end
        run_txn(1'b1, 10'd640, 9'd0, rand36(), rand36(), 0, 1'b0, 1'b0);
        total++; if (o_we_cnt !== 0 || o_drv_cnt !== 0) begin bad++; $display("FAIL oobx_ram got we %0d drv %0d want 0/0", o_we_cnt, o_drv_cnt); end
        run_txn(1'b0, 10'd1, 9'd1, 36'h0, 36'h5A5A5A5A5, 0, 1'b0, 1'b0);
        total++; if (lpf_oob !== 1'b1 || o_rval !== 36'h5A5A5A5A5) begin bad++; $display("FAIL oob_sticky got %0b %h want 1 5A5A5A5A5", lpf_oob, o_rval); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic        wr, ff, oob;
            int          x, y, a, gd;
            logic [35:0] wd, rd, want;
            wr = 1'($urandom_range(0, 1));
            ff = ($urandom_range(0, 3) == 0);
            gd = $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) begin
                x = $urandom_range(600, 1023); y = $urandom_range(450, 511);
            end else begin
                x = $urandom_range(0, 639); y = $urandom_range(0, 479);
            end
            oob = (x >= 640) || (y >= 480);
            a = exp_addr(buf_m, x, y);
            wd = rand36();
            if (!mem.exists(a)) mem[a] = rand36();
            rd = mem[a];
            want = oob ? 36'd0 : rd;
            run_txn(wr, 10'(x), 9'(y), wd, rd, gd, ff, 1'b0);
            if (ff) buf_m = ~buf_m;
            if (oob) oob_m = 1'b1;
            total++; if (o_done_cyc !== 4 || o_done_cnt !== 1) begin bad++; $display("FAIL rnd%0d_done got cyc %0d cnt %0d want 4/1", n, o_done_cyc, o_done_cnt); end
            total++; if (o_wait_bad !== 0 || o_req !== 5'b01111) begin bad++; $display("FAIL rnd%0d_req got waitbad %0d req %b want 0/01111", n, o_wait_bad, o_req); end
            if (oob) begin
                total++; if (o_we_cnt !== 0 || o_drv_cnt !== 0) begin bad++; $display("FAIL rnd%0d_oob got we %0d drv %0d want 0/0", n, o_we_cnt, o_drv_cnt); end
            end else begin
                total++; if (o_addr !== 19'(a)) begin bad++; $display("FAIL rnd%0d_addr got %0d want %0d", n, o_addr, a); end
            end
            if (wr) begin
                total++; if (!oob && (o_we_cyc !== 1 || o_drv_cyc !== 3 || o_drv_data !== wd)) begin bad++; $display("FAIL rnd%0d_write got we %0d drv %0d data %h want 1/3/%h", n, o_we_cyc, o_drv_cyc, o_drv_data, wd); end
                if (!oob) mem[a] = wd;
            end else begin
                total++; if (o_rval !== want || o_we_cnt !== 0) begin bad++; $display("FAIL rnd%0d_read got %h we %0d want %h/0", n, o_rval, o_we_cnt, want); end
            end
            total++; if (buf_sel !== buf_m || lpf_oob !== oob_m) begin bad++; $display("FAIL rnd%0d_flags got buf %0b oob %0b want %0b/%0b", n, buf_sel, lpf_oob, buf_m, oob_m); end
        end
    endtask

    task automatic test_frame_reset();
        logic old;
        int   dones;
        old = buf_m;
        lpf_flag = 1'b1; lpf_wr = 1'b0; lpf_x = 10'd4; lpf_y = 9'd1; ram_grant = 1'b1; frame_flag = 1'b1;
        @(posedge clock); #1;
        frame_flag = 1'b0;
        @(negedge clock);
        total++; if (ram_addr !== 19'(exp_addr(old, 4, 1))) begin bad++; $display("FAIL frame_old_base got %0d want %0d", ram_addr, exp_addr(old, 4, 1)); end
        total++; if (buf_sel !== ~old) begin bad++; $display("FAIL frame_toggled got %0b want %0b", buf_sel, ~old); end
        @(posedge clock); #1;
        reset = 1'b0; lpf_flag = 1'b0; ram_grant = 1'b0;
        #1;
        test_reset();
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            if (i == 2) reset = 1'b1;
            if (done_lpf === 1'b1) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL abort_done got %0d want 0", dones); end
        total++; if (buf_sel !== 1'b0 || lpf_oob !== 1'b0) begin bad++; $display("FAIL abort_flags got %0b %0b want 0/0", buf_sel, lpf_oob); end
        buf_m = 1'b0; oob_m = 1'b0;
    endtask

    initial begin
        reset = 1'b0; frame_flag = 1'b0; lpf_flag = 1'b0; lpf_wr = 1'b0; lpf_x = '0; lpf_y = '0;
        lpf_pixel_write = '0; ram_grant = 1'b0; ram_data_in = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        test_read();
        test_write();
        test_back_to_back();
        test_grant_wait();
        test_oob();
        test_random();
        test_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
